// File: rtl/multiport_arb_ram_pkg.sv
// Shared types and helpers for the arbitrated multiport RAM.
package mpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned PARITY_MAX_W = 64;

    // Low bit of slice idx in a vector packed from width-bit fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/multiport_arb_ram_if.sv
// Per-port request/grant bus of the arbitrated multiport RAM (MPRAM_PARITY_EN adds perr).
interface multiport_arb_ram_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MEM_WIDTH  = 12,
    parameter int unsigned PORT_COUNT = 2
);
    logic [PORT_COUNT-1:0]            req;
    logic [PORT_COUNT-1:0]            mem_write;
    logic [ADDR_WIDTH*PORT_COUNT-1:0] address;
    logic [MEM_WIDTH*PORT_COUNT-1:0]  datain;
    logic [PORT_COUNT-1:0]            gnt;
    logic [PORT_COUNT-1:0]            rvalid;
    logic [MEM_WIDTH*PORT_COUNT-1:0]  dataout;
    logic                             busy;
`ifdef MPRAM_PARITY_EN
    logic [PORT_COUNT-1:0]            perr;
`endif

    modport master (
        output req, mem_write, address, datain,
        input  gnt, rvalid, dataout, busy
`ifdef MPRAM_PARITY_EN
        , input perr
`endif
    );

    modport slave (
        input  req, mem_write, address, datain,
        output gnt, rvalid, dataout, busy
`ifdef MPRAM_PARITY_EN
        , output perr
`endif
    );
endinterface

// File: rtl/multiport_arb_ram_rr_arbiter.sv
// Round-robin pick among one group of colliding writers.
module mpram_rr_arbiter #(
    parameter  int unsigned PORT_COUNT = 2,
    localparam int unsigned PTR_W      = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic [PORT_COUNT-1:0] req_i,
    input  logic [PTR_W-1:0]      ptr_i,
    output logic [PORT_COUNT-1:0] win_o,
    output logic [PTR_W-1:0]      next_ptr_o
);

    int unsigned idx_c;
    logic        found_c;

    // Scan upward from ptr_i with wrap; first requester wins, pointer moves past it.
    always_comb begin
        win_o      = '0;
        next_ptr_o = ptr_i;
        found_c    = 1'b0;
        idx_c      = 0;
        for (int unsigned k = 0; k < PORT_COUNT; k++) begin
            idx_c = (32'(ptr_i) + k) % PORT_COUNT;
            if (!found_c && req_i[PTR_W'(idx_c)]) begin
                found_c                = 1'b1;
                win_o[PTR_W'(idx_c)]   = 1'b1;
                next_ptr_o             = PTR_W'((idx_c + 1) % PORT_COUNT);
            end
        end
    end

endmodule

// File: rtl/multiport_arb_ram.sv
// N-port RAM with request/grant, round-robin write-collision arbitration,
// write-first bypass and a post-reset clear sweep.
// Optional macro MPRAM_PARITY_EN: per-word even parity and perr output.
module multiport_arb_ram
    import mpram_pkg::*;
#(
    parameter int unsigned MEM_SIZE   = 4096,
    parameter int unsigned MEM_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned PORT_COUNT = 2
) (
    input  logic              clk,
    input  logic              reset,
    multiport_arb_ram_if.slave bus
);

    localparam int unsigned PTR_W  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    localparam int unsigned MAW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
`ifdef MPRAM_PARITY_EN
    localparam int unsigned WORD_W = MEM_WIDTH + 1;
`else
    localparam int unsigned WORD_W = MEM_WIDTH;
`endif

    state_e                 state_q, state_d;
    logic [MAW-1:0]         clr_q, clr_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic                   busy_q, busy_d;
    logic                   coll_found_c;

    logic [ADDR_WIDTH-1:0]  addr_c     [PORT_COUNT];
    logic [MEM_WIDTH-1:0]   din_c      [PORT_COUNT];
    logic [WORD_W-1:0]      wr_word_c  [PORT_COUNT];
    logic [WORD_W-1:0]      rd_word_c  [PORT_COUNT];
    logic [MEM_WIDTH-1:0]   byp_data_c [PORT_COUNT];
    logic [MEM_WIDTH-1:0]   rd_data_c  [PORT_COUNT];
    logic [MEM_WIDTH-1:0]   dout_q     [PORT_COUNT];
    logic [PORT_COUNT-1:0]  match_c    [PORT_COUNT];
    logic [PORT_COUNT-1:0]  win_c      [PORT_COUNT];
    logic [PTR_W-1:0]       nxt_c      [PORT_COUNT];
    logic [PORT_COUNT-1:0]  win_any_c, in_range_c, byp_c;
    logic [PORT_COUNT-1:0]  wr_req_c, gnt_c, wr_gnt_c, rd_gnt_c, rvalid_q;

    logic [WORD_W-1:0]      mem_q [MEM_SIZE];

    assign wr_req_c = bus.req & bus.mem_write;
    assign wr_gnt_c = gnt_c & bus.mem_write;
    assign rd_gnt_c = gnt_c & ~bus.mem_write;

    // Per-port unpacking, pairwise same-address writer matrix and one arbiter per group.
    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        assign addr_c[p]     = bus.address[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
        assign din_c[p]      = bus.datain[slice_lo(p, MEM_WIDTH) +: MEM_WIDTH];
        assign in_range_c[p] = 32'(addr_c[p]) < MEM_SIZE;
        assign bus.dataout[slice_lo(p, MEM_WIDTH) +: MEM_WIDTH] = dout_q[p];
        for (genvar q = 0; q < PORT_COUNT; q++) begin : g_match
            assign match_c[p][q] = wr_req_c[p] & wr_req_c[q] & (addr_c[p] == addr_c[q]);
        end
        mpram_rr_arbiter #(.PORT_COUNT(PORT_COUNT)) u_arb (
            .req_i      (match_c[p]),
            .ptr_i      (rr_q),
            .win_o      (win_c[p]),
            .next_ptr_o (nxt_c[p])
        );
        assign gnt_c[p] = (state_q == READY) & bus.req[p] & (~bus.mem_write[p] | win_any_c[p]);
    end

    // A writer is granted when it wins its own address group (a lone writer always does).
    always_comb begin
        win_any_c = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            win_any_c = win_any_c | win_c[p];
        end
    end

    // Clear sweep sequencing and round-robin pointer update.
    always_comb begin
        state_d      = state_q;
        clr_d        = clr_q;
        rr_d         = rr_q;
        coll_found_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (32'(clr_q) == MEM_SIZE - 1) begin
                    state_d = READY;
                    clr_d   = '0;
                end
            end
            READY: begin
                for (int p = 0; p < PORT_COUNT; p++) begin
                    if (!coll_found_c && ((match_c[p] & (match_c[p] - 1'b1)) != '0)) begin
                        coll_found_c = 1'b1;
                        rr_d         = nxt_c[p];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    // Stored word formation, parity bit appended when enabled.
    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
`ifdef MPRAM_PARITY_EN
            wr_word_c[p] = {even_parity(PARITY_MAX_W'(din_c[p])), din_c[p]};
`else
            wr_word_c[p] = din_c[p];
`endif
        end
    end

    // Storage: zeroed word by word while clearing, granted in-range writes when ready.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_q] <= '0;
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (wr_gnt_c[p] && in_range_c[p]) begin
                    mem_q[MAW'(addr_c[p])] <= wr_word_c[p];
                end
            end
        end
    end

    // Read data selection: out-of-range zero, else write-first bypass, else stored word.
    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            rd_word_c[p]  = mem_q[MAW'(addr_c[p])];
            byp_c[p]      = 1'b0;
            byp_data_c[p] = '0;
            for (int q = 0; q < PORT_COUNT; q++) begin
                if (wr_gnt_c[q] && (addr_c[q] == addr_c[p])) begin
                    byp_c[p]      = 1'b1;
                    byp_data_c[p] = din_c[q];
                end
            end
            if (!in_range_c[p]) begin
                rd_data_c[p] = '0;
            end else if (byp_c[p]) begin
                rd_data_c[p] = byp_data_c[p];
            end else begin
                rd_data_c[p] = rd_word_c[p][MEM_WIDTH-1:0];
            end
        end
    end

`ifdef MPRAM_PARITY_EN
    logic [PORT_COUNT-1:0] perr_c, perr_q;

    // Parity check on stored words only; bypassed and out-of-range reads never flag.
    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            perr_c[p] = in_range_c[p] & ~byp_c[p] &
                        (even_parity(PARITY_MAX_W'(rd_word_c[p][MEM_WIDTH-1:0])) != rd_word_c[p][MEM_WIDTH]);
        end
    end

    // Parity error flag, aligned with rvalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= '0;
        end else begin
            perr_q <= rd_gnt_c & perr_c;
        end
    end

    assign bus.perr = perr_q;
`endif

    // Registered read response; data holds when no read was granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                dout_q[p] <= '0;
            end
        end else begin
            rvalid_q <= rd_gnt_c;
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (rd_gnt_c[p]) begin
                    dout_q[p] <= rd_data_c[p];
                end
            end
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_multiport_arb_ram.sv
// Testbench for multiport_arb_ram: directed vector table plus randomized traffic
// checked against a behavioural model of the grant/read/clear rules.
module tb_multiport_arb_ram;

    localparam int MS = 4096;
    localparam int AW = 12;
    localparam int MW = 12;
    localparam int PC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multiport_arb_ram_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .PORT_COUNT(PC)) bus ();

    multiport_arb_ram #(.MEM_SIZE(MS), .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .PORT_COUNT(PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [MW-1:0] mmem [MS];
    int            m_rr;
    int            m_busy_left;
    logic [PC-1:0] m_rv;
    logic [MW-1:0] m_dout [PC];

    // Inputs of the current cycle
    logic [PC-1:0] cur_rq, cur_wr;
    logic [AW-1:0] cur_a [PC];
    logic [MW-1:0] cur_d [PC];

    typedef struct {
        logic [1:0]  rq;
        logic [1:0]  wr;
        logic [11:0] a0, a1, d0, d1;
        logic [1:0]  eg;
        logic [1:0]  ev;
        logic [11:0] e0, e1;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit is_writer(int q);
        return cur_rq[q] && cur_wr[q];
    endfunction

    function automatic int writers_at(logic [AW-1:0] a);
        int n = 0;
        for (int q = 0; q < PC; q++) if (is_writer(q) && cur_a[q] == a) n++;
        return n;
    endfunction

    // Round-robin winner: first writer to this address scanning up from m_rr.
    function automatic int winner_at(logic [AW-1:0] a);
        for (int k = 0; k < PC; k++) begin
            int idx = (m_rr + k) % PC;
            if (is_writer(idx) && cur_a[idx] == a) return idx;
        end
        return -1;
    endfunction

    function automatic logic [PC-1:0] model_gnt();
        logic [PC-1:0] g = '0;
        if (m_busy_left > 0) return '0;
        for (int p = 0; p < PC; p++) begin
            if (cur_rq[p]) begin
                if (!cur_wr[p]) g[p] = 1'b1;
                else if (writers_at(cur_a[p]) == 1) g[p] = 1'b1;
                else g[p] = (winner_at(cur_a[p]) == p);
            end
        end
        return g;
    endfunction

    task automatic model_commit(input logic [PC-1:0] g);
        int new_rr;
        if (m_busy_left > 0) begin
            m_busy_left--;
            m_rv = '0;
            return;
        end
        for (int p = 0; p < PC; p++) begin
            m_rv[p] = g[p] && !cur_wr[p];
            if (m_rv[p]) begin
                logic [MW-1:0] v;
                v = (int'(cur_a[p]) >= MS) ? '0 : mmem[cur_a[p]];
                for (int q = 0; q < PC; q++)
                    if (g[q] && cur_wr[q] && cur_a[q] == cur_a[p]) v = cur_d[q];
                m_dout[p] = v;
            end
        end
        new_rr = m_rr;
        for (int p = PC - 1; p >= 0; p--)
            if (is_writer(p) && writers_at(cur_a[p]) > 1) new_rr = (winner_at(cur_a[p]) + 1) % PC;
        for (int p = 0; p < PC; p++)
            if (g[p] && cur_wr[p] && int'(cur_a[p]) < MS) mmem[cur_a[p]] = cur_d[p];
        m_rr = new_rr;
    endtask

    // One clock: drive at negedge, check grant, clock, check registered outputs.
    task automatic step(input logic [1:0] rq, input logic [1:0] wr,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [11:0] d0, input logic [11:0] d1,
                        output logic [1:0] og, output logic [1:0] orv,
                        output logic [11:0] od0, output logic [11:0] od1);
        logic [1:0] eg;
        cur_rq = rq; cur_wr = wr;
        cur_a[0] = a0; cur_a[1] = a1; cur_d[0] = d0; cur_d[1] = d1;
        bus.req = rq; bus.mem_write = wr;
        bus.address = {a1, a0}; bus.datain = {d1, d0};
        #1;
        eg = model_gnt();
        og = bus.gnt;
        chk("gnt", 32'(og), 32'(eg));
        @(posedge clk);
        model_commit(eg);
        #1;
        orv = bus.rvalid;
        od0 = bus.dataout[11:0];
        od1 = bus.dataout[23:12];
        chk("rvalid", 32'(orv), 32'(m_rv));
        chk("dout0", 32'(od0), 32'(m_dout[0]));
        chk("dout1", 32'(od1), 32'(m_dout[1]));
        chk("busy", 32'(bus.busy), 32'(m_busy_left > 0));
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req = '0; bus.mem_write = '0; bus.address = '0; bus.datain = '0;
        reset = 1'b0;
        for (int i = 0; i < MS; i++) mmem[i] = '0;
        m_rr = 0; m_busy_left = MS; m_rv = '0; m_dout[0] = '0; m_dout[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_dout", 32'(bus.dataout), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
    endtask

    // Run until busy drops (bounded), hammering with random requests; returns busy cycle count.
    task automatic run_clear(output int busy_cnt);
        logic [1:0] og, orv;
        logic [11:0] od0, od1;
        busy_cnt = 0;
        for (int i = 0; i < MS + 200; i++) begin
            if (!bus.busy) break;
            busy_cnt++;
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 12'($urandom_range(0, 7)), 12'($urandom_range(0, 7)),
                 12'($urandom), 12'($urandom), og, orv, od0, od1);
        end
    endtask

    initial begin
        logic [1:0] og, orv;
        logic [11:0] od0, od1;
        int bc;

        tv[0] = '{2'b11, 2'b00, 12'h000, 12'hFFF, 12'h000, 12'h000, 2'b11, 2'b11, 12'h000, 12'h000};
        tv[1] = '{2'b11, 2'b11, 12'h001, 12'h004, 12'hABC, 12'h123, 2'b11, 2'b00, 12'h000, 12'h000};
        tv[2] = '{2'b11, 2'b00, 12'h001, 12'h004, 12'h000, 12'h000, 2'b11, 2'b11, 12'hABC, 12'h123};
        tv[3] = '{2'b11, 2'b11, 12'h010, 12'h010, 12'h111, 12'h222, 2'b01, 2'b00, 12'hABC, 12'h123};
        tv[4] = '{2'b11, 2'b11, 12'h010, 12'h010, 12'h111, 12'h222, 2'b10, 2'b00, 12'hABC, 12'h123};
        tv[5] = '{2'b11, 2'b00, 12'h010, 12'h010, 12'h000, 12'h000, 2'b11, 2'b11, 12'h222, 12'h222};
        tv[6] = '{2'b11, 2'b11, 12'h010, 12'h010, 12'h333, 12'h444, 2'b01, 2'b00, 12'h222, 12'h222};
        tv[7] = '{2'b10, 2'b00, 12'h000, 12'h010, 12'h000, 12'h000, 2'b10, 2'b10, 12'h222, 12'h333};
        tv[8] = '{2'b11, 2'b01, 12'h020, 12'h020, 12'h5A5, 12'h000, 2'b11, 2'b10, 12'h222, 12'h5A5};
        tv[9] = '{2'b11, 2'b00, 12'h020, 12'h001, 12'h000, 12'h000, 2'b11, 2'b11, 12'h5A5, 12'hABC};

        // Power-up clear: busy exactly MS cycles, requests refused meanwhile
        do_reset();
        run_clear(bc);
        chk("busy_len", 32'(bc), 32'(MS));

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            step(tv[i].rq, tv[i].wr, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1, og, orv, od0, od1);
            chk($sformatf("tv%0d_gnt", i), 32'(og), 32'(tv[i].eg));
            chk($sformatf("tv%0d_rvalid", i), 32'(orv), 32'(tv[i].ev));
            chk($sformatf("tv%0d_dout0", i), 32'(od0), 32'(tv[i].e0));
            chk($sformatf("tv%0d_dout1", i), 32'(od1), 32'(tv[i].e1));
        end

        // Random traffic on a small address set to provoke collisions and bypasses
        for (int i = 0; i < 600; i++) begin
            logic [11:0] ra0, ra1;
            ra0 = ($urandom_range(0, 8) == 8) ? 12'hFFF : 12'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 8) == 8) ? 12'hFFF : 12'($urandom_range(0, 7));
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ra0, ra1,
                 12'($urandom), 12'($urandom), og, orv, od0, od1);
        end

        // Reset 100 cycles into the sweep: the sweep restarts and lasts a full MS cycles
        do_reset();
        for (int i = 0; i < 100; i++) step(2'b11, 2'b11, 12'h003, 12'h005, 12'h7E7, 12'h1D1, og, orv, od0, od1);
        do_reset();
        run_clear(bc);
        chk("busy_len_restart", 32'(bc), 32'(MS));
        for (int i = 0; i < 8; i += 2) begin
            step(2'b11, 2'b00, 12'(i), 12'(i + 1), 12'h0, 12'h0, og, orv, od0, od1);
            chk("clr_mem", 32'({od1, od0}), 32'h0);
        end

`ifdef MPRAM_PARITY_EN
        // Corrupt a stored bit: next stored read flags, clean and bypassed reads do not
        step(2'b01, 2'b01, 12'h030, 12'h000, 12'h0F0, 12'h000, og, orv, od0, od1);
        dut.mem_q[12'h030][0] = ~dut.mem_q[12'h030][0];
        mmem[12'h030][0] = ~mmem[12'h030][0];
        step(2'b01, 2'b00, 12'h030, 12'h000, 12'h000, 12'h000, og, orv, od0, od1);
        chk("perr_bad", 32'(bus.perr), 32'h1);
        step(2'b01, 2'b00, 12'h001, 12'h000, 12'h000, 12'h000, og, orv, od0, od1);
        chk("perr_clean", 32'(bus.perr), 32'h0);
        step(2'b11, 2'b01, 12'h040, 12'h040, 12'h777, 12'h000, og, orv, od0, od1);
        chk("perr_bypass", 32'(bus.perr), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_arb_ram.md
Name: multiport_arb_ram

Overview:
- Parametrised N-port synchronous RAM. Successor to the team's multiport dynamic RAM.
- Adds four things:
  - a per-port request/grant handshake;
  - round-robin arbitration of same-address write collisions;
  - write-first read bypass;
  - a hardware clear sequencer that zeroes memory after reset.
- Sits between processor/DMA masters and the shared data store.

Parameters:
- MEM_SIZE, 4096, number of words.
- MEM_WIDTH, 12, bits per word.
- ADDR_WIDTH, 12, address bits per port. Must satisfy MEM_SIZE <= 2**ADDR_WIDTH.
- PORT_COUNT, 2, number of ports. Legal range 1..8.

Ports:
- clk  in  1  — single clock, all state on rising edge.
- reset  in  1  — asynchronous, active-low.
- req  in  PORT_COUNT  — per-port access request.
- mem_write  in  PORT_COUNT  — per-port write (1) / read (0). Qualified by req.
- address  in  ADDR_WIDTH*PORT_COUNT  — packed addresses; port p = bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- datain  in  MEM_WIDTH*PORT_COUNT  — packed write data, same packing as address.
- gnt  out  PORT_COUNT  — combinational grant, same cycle as req.
- rvalid  out  PORT_COUNT  — read data valid, one cycle after a granted read.
- dataout  out  MEM_WIDTH*PORT_COUNT  — packed registered read data.
- busy  out  1  — clear sequencer active; all requests refused.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - gnt=0, rvalid=0, dataout=0, busy=1;
  - FSM to CLEAR, clear pointer to 0, round-robin pointer to 0.
- Memory contents are not reset directly; the clear sequencer zeroes them.

FSM:
- CLEAR:
  - Writes 0 to word clr_ptr each cycle; clr_ptr increments.
  - When clr_ptr == MEM_SIZE-1 is written, go to READY next cycle.
  - busy=1 for exactly MEM_SIZE cycles after reset deasserts.
- READY:
  - busy=0. Normal operation. FSM never leaves READY except on reset.
- Reset asserted mid-CLEAR restarts the sweep from address 0.

Grant rules (READY only; gnt=0 for all ports while busy):
- Reads are always granted.
- A write is granted unless another requesting write targets the same address.
- Among colliding writers, grant one port: the first port at or after rr_ptr, scanning upward with wrap-around.
- Losers get gnt=0, commit nothing, and must hold req/address/datain until granted.
- After any collision cycle, rr_ptr = winner+1 mod PORT_COUNT. Otherwise rr_ptr holds.
- Writes by different ports to distinct addresses in one cycle all commit.

Read path:
- A granted read at cycle t gives rvalid[p]=1 and dataout slice p valid at cycle t+1 (latency 1).
- dataout slice holds its last value when rvalid[p]=0.

Read-during-write:
- Granted read and granted write to the same address in the same cycle: read returns the new write data (write-first bypass).
- If several writes were presented, the bypass uses the winner's data.

Address range:
- address >= MEM_SIZE: read returns 0 with rvalid=1; write is granted and discarded.

Arithmetic:
- Address comparisons are full ADDR_WIDTH equality.
- rr_ptr is $clog2(PORT_COUNT) bits, minimum 1 bit.

Optional Feature:
- Macro MPRAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed on write; CLEAR writes parity 0.
  - Adds output perr [PORT_COUNT], registered alongside rvalid. Asserts when stored parity mismatches stored data on a granted read.
  - Bypassed reads never flag.
- Undefined:
  - No extra bit, no perr port.
  - Storage exactly MEM_SIZE x MEM_WIDTH.

Decomposition:
- Package mpram_pkg holds:
  - state enum {CLEAR, READY};
  - a function for the packed-slice index;
  - a parity function.
- Sub-module mpram_rr_arbiter:
  - takes a PORT_COUNT collision-request vector plus rr_ptr;
  - returns a one-hot winner and the next pointer.
- Top instantiates one arbiter per collision group; a generate loop builds a pairwise same-address match matrix.

Test Plan:
- Clear: release reset → busy=1 for 4096 cycles, then 0. A read of addr 0x000 and of addr 0xFFF each returns 0 with rvalid one cycle later.
- Parallel writes: port0 writes 0xABC@0x001, port1 writes 0x123@0x004 in one cycle → both gnt=1. Next-cycle reads return 0xABC and 0x123.
- Collision: both ports write 0x010 (0x111 vs 0x222), rr_ptr=0 → port0 granted. Port1 holds and is granted next cycle. Final read 0x222. The next collision is won by port0 again (rr_ptr wrapped to 0 after port1 won).
- Bypass: port0 writes 0x5A5@0x020 while port1 reads 0x020 in the same cycle → port1 dataout=0x5A5 at t+1.
- Reset mid-clear: assert reset at cycle 100 of CLEAR, release → busy lasts a full 4096 cycles again. Requests during busy see gnt=0 and memory is unchanged.
- Parity (MPRAM_PARITY_EN): force a stored data bit flip via hierarchical poke, then read → perr=1 with rvalid. Clean read → perr=0.
